// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop counter family: direction constants,
// the MAX computation and the elaboration-time parameter legality check.
package tff_pkg;

  localparam logic TFF_DIR_UP = 1'b1;
  localparam logic TFF_DIR_DN = 1'b0;

  // Largest code the counter reaches; modulus 0 selects the full binary range.
  function automatic longint unsigned tff_max(int unsigned width, longint unsigned modulus);
    if (modulus == 0) begin
      return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    end
    return modulus - 64'd1;
  endfunction

  function automatic bit tff_params_ok(int unsigned width, longint unsigned modulus);
    longint unsigned span;
    span = (width >= 64) ? '1 : (64'd1 << width);
    return (width >= 1) && ((modulus == 0) || ((modulus >= 2) && (modulus <= span)));
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: synchronous active-low clear, then parallel load, then toggle.
module tff_cell (
  input  logic clk,
  input  logic clr_n,
  input  logic t_i,
  input  logic ld_i,
  input  logic ld_d_i,
  output logic q_o
);

  logic state_q;

  // NOTE: the clear is sampled only on the clock edge, so it sits inside the
  // edge-triggered block rather than in the sensitivity list; <= keeps every
  // cell updating from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= 1'b0;
    end else if (ld_i) begin
      state_q <= ld_d_i;
    end else if (t_i) begin
      state_q <= ~state_q;
    end
  end

  assign q_o = state_q;

endmodule

// File: rtl/tff_counter.sv
// Width/modulus-configurable up/down counter built from tff_cell bits.
// Define TFF_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module tff_counter
  import tff_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(tff_max(WIDTH, MODULUS));

  if (!tff_params_ok(WIDTH, MODULUS)) begin : g_bad_params
    $error("tff_counter: WIDTH must be >= 1 and MODULUS 0 or in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] t_d;
  logic [WIDTH-1:0] ld_val;
  logic             at_limit;
  logic             wrap_d;
  logic             wrap_q;

  assign at_limit = (up == TFF_DIR_UP) ? (cnt_q == MAX) : (cnt_q == '0);
  assign ld_val   = (d > MAX) ? MAX : d;

  always_comb begin
    // NOTE: blocking assignments here build the ripple chain bit by bit; each
    // t_d[i] is read after it was written earlier in the same pass.
    t_d    = '0;
    t_d[0] = en;
    for (int i = 1; i < WIDTH; i++) begin
      t_d[i] = t_d[i-1] & (cnt_q[i-1] ~^ up);
    end
    wrap_d = 1'b0;
    if (en && at_limit) begin
`ifdef TFF_COUNTER_SAT_EN
      t_d = '0;
`else
      // Toggle exactly the bits that differ from the wrap target (0 or MAX).
      t_d    = (up == TFF_DIR_UP) ? cnt_q : (cnt_q ^ MAX);
      wrap_d = !load;
`endif
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk    (clk),
      .clr_n  (clr_n),
      .t_i    (t_d[i]),
      .ld_i   (load),
      .ld_d_i (ld_val[i]),
      .q_o    (cnt_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign q    = cnt_q;
  assign tc   = at_limit;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter: 8-bit binary, 4-bit modulus-10 and 4-bit binary
// instances; saturation checks run when TFF_COUNTER_SAT_EN is defined.
module tb_tff_counter;

  logic       clk = 1'b0;
  logic       clr_n, en, up, load;
  logic [7:0] d8, q8;
  logic [3:0] d4, q10, qs;
  logic       tc8, wrap8, tc10, wrap10, tcs, wraps;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  tff_counter #(.WIDTH(8), .MODULUS(0)) u_dut8 (
    .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load),
    .d(d8), .q(q8), .tc(tc8), .wrap(wrap8)
  );

  tff_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
    .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load),
    .d(d4), .q(q10), .tc(tc10), .wrap(wrap10)
  );

  tff_counter #(.WIDTH(4), .MODULUS(0)) u_duts (
    .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load),
    .d(d4), .q(qs), .tc(tcs), .wrap(wraps)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; en = 1'b1; load = 1'b1; up = 1'b1; d8 = 8'hA5; d4 = 4'h5;
    step();
    step();
    n_cmp++; if (q8 !== 8'h00) begin n_err++; $display("FAIL reset_q8 got %h exp 00", q8); end
    n_cmp++; if (wrap8 !== 1'b0) begin n_err++; $display("FAIL reset_wrap8 got %b exp 0", wrap8); end
    n_cmp++; if (tc8 !== 1'b0) begin n_err++; $display("FAIL reset_tc8 got %b exp 0", tc8); end
    n_cmp++; if (q10 !== 4'h0) begin n_err++; $display("FAIL reset_q10 got %h exp 0", q10); end
    n_cmp++; if (wrap10 !== 1'b0) begin n_err++; $display("FAIL reset_wrap10 got %b exp 0", wrap10); end
  endtask

  task automatic test_hold();
    clr_n = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1;
    step();
    step();
    n_cmp++; if (q8 !== 8'h00) begin n_err++; $display("FAIL hold_q8 got %h exp 00", q8); end
    n_cmp++; if (wrap8 !== 1'b0) begin n_err++; $display("FAIL hold_wrap8 got %b exp 0", wrap8); end
    up = 1'b0;
    #1;
    n_cmp++; if (tc8 !== 1'b1) begin n_err++; $display("FAIL hold_tc8_down got %b exp 1", tc8); end
    step();
    n_cmp++; if (q8 !== 8'h00) begin n_err++; $display("FAIL hold_q8_down got %h exp 00", q8); end
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp_q [3] = '{8'hFF, 8'h00, 8'h01};
    logic       exp_w [3] = '{1'b0, 1'b1, 1'b0};
    logic       exp_t [3] = '{1'b1, 1'b0, 1'b0};
    load = 1'b1; en = 1'b0; up = 1'b1; d8 = 8'hFE;
    step();
    n_cmp++; if (q8 !== 8'hFE) begin n_err++; $display("FAIL upwrap_load got %h exp FE", q8); end
    n_cmp++; if (tc8 !== 1'b0) begin n_err++; $display("FAIL upwrap_tc_fe got %b exp 0", tc8); end
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (q8 !== exp_q[i]) begin n_err++; $display("FAIL upwrap_q[%0d] got %h exp %h", i, q8, exp_q[i]); end
      n_cmp++; if (wrap8 !== exp_w[i]) begin n_err++; $display("FAIL upwrap_wrap[%0d] got %b exp %b", i, wrap8, exp_w[i]); end
      n_cmp++; if (tc8 !== exp_t[i]) begin n_err++; $display("FAIL upwrap_tc[%0d] got %b exp %b", i, tc8, exp_t[i]); end
    end
  endtask

  task automatic test_modulus();
    logic [3:0] exp_q;
    clr_n = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;
    step();
    clr_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_q = 4'((i + 1) % 10);
      n_cmp++; if (q10 !== exp_q) begin n_err++; $display("FAIL mod10_q[%0d] got %h exp %h", i, q10, exp_q); end
      n_cmp++; if (wrap10 !== (i == 9)) begin n_err++; $display("FAIL mod10_wrap[%0d] got %b exp %b", i, wrap10, (i == 9)); end
      n_cmp++; if (tc10 !== (exp_q == 4'd9)) begin n_err++; $display("FAIL mod10_tc[%0d] got %b exp %b", i, tc10, (exp_q == 4'd9)); end
    end
  endtask

  task automatic test_load_clamp();
    load = 1'b1; en = 1'b1; up = 1'b1; d4 = 4'hC;
    step();
    n_cmp++; if (q10 !== 4'd9) begin n_err++; $display("FAIL clamp_c_q10 got %h exp 9", q10); end
    n_cmp++; if (wrap10 !== 1'b0) begin n_err++; $display("FAIL clamp_c_wrap10 got %b exp 0", wrap10); end
    n_cmp++; if (qs !== 4'hC) begin n_err++; $display("FAIL clamp_c_qs got %h exp C", qs); end
    d4 = 4'hA;
    step();
    n_cmp++; if (q10 !== 4'd9) begin n_err++; $display("FAIL clamp_a_q10 got %h exp 9", q10); end
    d4 = 4'h8;
    step();
    n_cmp++; if (q10 !== 4'd8) begin n_err++; $display("FAIL clamp_8_q10 got %h exp 8", q10); end
    load = 1'b0;
  endtask

  task automatic test_down_flip();
    logic [7:0] exp8  [4] = '{8'h02, 8'h01, 8'h00, 8'hFF};
    logic [3:0] exp10 [4] = '{4'h2, 4'h1, 4'h0, 4'h9};
    load = 1'b1; en = 1'b0; d8 = 8'h03; d4 = 4'h3;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        n_cmp++; if (tc10 !== 1'b1) begin n_err++; $display("FAIL down_tc10_at0 got %b exp 1", tc10); end
      end
      step();
      n_cmp++; if (q8 !== exp8[i]) begin n_err++; $display("FAIL down_q8[%0d] got %h exp %h", i, q8, exp8[i]); end
      n_cmp++; if (q10 !== exp10[i]) begin n_err++; $display("FAIL down_q10[%0d] got %h exp %h", i, q10, exp10[i]); end
      n_cmp++; if (wrap10 !== (i == 3)) begin n_err++; $display("FAIL down_wrap10[%0d] got %b exp %b", i, wrap10, (i == 3)); end
    end
    up = 1'b1;
    step();
    n_cmp++; if (q8 !== 8'h00) begin n_err++; $display("FAIL flip_q8 got %h exp 00", q8); end
    n_cmp++; if (q10 !== 4'h0) begin n_err++; $display("FAIL flip_q10 got %h exp 0", q10); end
    n_cmp++; if (wrap10 !== 1'b1) begin n_err++; $display("FAIL flip_wrap10 got %b exp 1", wrap10); end
  endtask

  task automatic test_priority();
    load = 1'b1; en = 1'b1; up = 1'b1; d8 = 8'h05; d4 = 4'h5;
    step();
    n_cmp++; if (q8 !== 8'h05) begin n_err++; $display("FAIL prio_load_q8 got %h exp 05", q8); end
    n_cmp++; if (q10 !== 4'h5) begin n_err++; $display("FAIL prio_load_q10 got %h exp 5", q10); end
    clr_n = 1'b0; d8 = 8'hA5;
    step();
    n_cmp++; if (q8 !== 8'h00) begin n_err++; $display("FAIL prio_clr_q8 got %h exp 00", q8); end
    n_cmp++; if (q10 !== 4'h0) begin n_err++; $display("FAIL prio_clr_q10 got %h exp 0", q10); end
    clr_n = 1'b1; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_saturate();
    load = 1'b1; en = 1'b0; up = 1'b1; d4 = 4'hE;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (qs !== 4'hF) begin n_err++; $display("FAIL sat_up_q[%0d] got %h exp F", i, qs); end
      n_cmp++; if (wraps !== 1'b0) begin n_err++; $display("FAIL sat_up_wrap[%0d] got %b exp 0", i, wraps); end
      n_cmp++; if (tcs !== 1'b1) begin n_err++; $display("FAIL sat_up_tc[%0d] got %b exp 1", i, tcs); end
    end
    load = 1'b1; en = 1'b0; d4 = 4'h1;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (qs !== 4'h0) begin n_err++; $display("FAIL sat_dn_q[%0d] got %h exp 0", i, qs); end
      n_cmp++; if (wraps !== 1'b0) begin n_err++; $display("FAIL sat_dn_wrap[%0d] got %b exp 0", i, wraps); end
    end
    en = 1'b0;
  endtask

  initial begin
    clr_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d8 = '0; d4 = '0;
    #2;
    test_reset();
    test_hold();
`ifdef TFF_COUNTER_SAT_EN
    test_saturate();
`else
    test_up_wrap();
    test_modulus();
    test_down_flip();
`endif
    test_load_clamp();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
